adder4_stim_checker: RTL and testbench

- Hardware stimulus driver and response checker for the 4-operand 1-bit adder, which reduces A,B,C,D to a 3-bit count {C1,C2,sum}.
- Walks every operand combination in ascending order, holds each one until the adder output has settled, then compares the adder result against a golden popcount.
- Reports pass/fail, the error count and the first failing vector.
- Used for on-chip self-test and as the synthesizable form of the exhaustive truth-table bench.

---
 rtl/adder4_pkg.sv | 16 +
 rtl/adder4_stim_checker_if.sv | 27 ++
 rtl/adder4_golden.sv | 14 +
 rtl/adder4_stim_checker.sv | 112 +++++++++++
 tb/tb_adder4_stim_checker.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/adder4_pkg.sv
// adder4_pkg: shared FSM state type, default sizes and popcount reference
//   state_t   : IDLE, HOLD, CHECK, FIN
//   N_IN_DEF  : default operand count
//   RES_W_DEF : default adder result width
//   popcount  : number of set bits in an up-to-8-bit operand vector
package adder4_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, CHECK, FIN} state_t;
   localparam int N_IN_DEF  = 4;
   localparam int RES_W_DEF = 3;
   function automatic logic [3:0] popcount(input logic [7:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
      return c;
   endfunction
endpackage

// File: rtl/adder4_stim_checker_if.sv
// adder4_stim_checker_if: bus between the sweep checker and its environment
//   start           : sweep request (env -> checker)
//   vec_o           : operands to the adder, bit 0 = D, MSB = A (checker -> adder)
//   res_i           : adder result {C1,C2,sum} (adder -> checker)
//   busy/done/pass  : sweep status (checker -> env)
//   err_cnt         : saturating mismatch count
//   first_err_valid : a mismatch was recorded; first_err_vec holds its vector
//   master modport = checker side, slave modport = environment side
interface adder4_stim_checker_if #(
   parameter int N_IN  = 4,
   parameter int RES_W = 3,
   parameter int ERR_W = 5
);
   logic              start;
   logic [N_IN-1:0]   vec_o;
   logic [RES_W-1:0]  res_i;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ERR_W-1:0]  err_cnt;
   logic              first_err_valid;
   logic [N_IN-1:0]   first_err_vec;
   modport master (input start, res_i,
                   output vec_o, busy, done, pass, err_cnt, first_err_valid, first_err_vec);
   modport slave  (output start, res_i,
                   input vec_o, busy, done, pass, err_cnt, first_err_valid, first_err_vec);
endinterface

// File: rtl/adder4_golden.sv
// adder4_golden: combinational expected adder result (popcount of the operands)
//   vec  : operand vector
//   gold : popcount(vec), zero-extended/truncated to RES_W
module adder4_golden
   import adder4_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int RES_W = RES_W_DEF
) (
   input  logic [N_IN-1:0]  vec,
   output logic [RES_W-1:0] gold
);
   assign gold = RES_W'(popcount(8'(vec)));
endmodule

// File: rtl/adder4_stim_checker.sv
// adder4_stim_checker: exhaustive stimulus driver and response checker for the N-operand 1-bit adder
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : adder4_stim_checker_if.master (start, vec_o, res_i, busy, done, pass,
//           err_cnt, first_err_valid, first_err_vec)
//   Optional macro ADDER4_STOP_ON_ERR_EN: end the sweep on the first mismatch,
//   leaving vec_o on the failing vector.
module adder4_stim_checker
   import adder4_pkg::*;
#(
   parameter int N_IN       = N_IN_DEF,
   parameter int RES_W      = $clog2(N_IN + 1),
   parameter int SETTLE_CYC = 1,
   parameter int ERR_W      = 5
) (
   input logic                  clk,
   input logic                  rst_n,
   adder4_stim_checker_if.master bus
);
   localparam logic [N_IN-1:0]  LAST = '1;
   localparam logic [ERR_W-1:0] EMAX = '1;
   localparam logic [3:0]       SET  = 4'(SETTLE_CYC);
   localparam state_t           FIRST = (SETTLE_CYC == 0) ? CHECK : HOLD;
   state_t            st, st_n;
   logic [N_IN-1:0]   vec, vec_n, fvec, fvec_n;
   logic [3:0]        cnt, cnt_n;
   logic [ERR_W-1:0]  err, err_n;
   logic              busy, busy_n, done, done_n, pass, pass_n, fev, fev_n;
   logic [RES_W-1:0]  gold;
   logic              mis, stop;
   adder4_golden #(.N_IN(N_IN), .RES_W(RES_W)) u_gold (.vec(vec), .gold(gold));
   assign mis = bus.res_i != gold;
`ifdef ADDER4_STOP_ON_ERR_EN
   assign stop = (vec == LAST) || mis;
`else
   assign stop = vec == LAST;
`endif
   always_comb begin
      st_n   = st;
      vec_n  = vec;
      cnt_n  = cnt;
      err_n  = err;
      pass_n = pass;
      fev_n  = fev;
      fvec_n = fvec;
      done_n = 1'b0;
      case (st)
         IDLE: if (bus.start) begin
            err_n  = '0;
            fev_n  = 1'b0;
            pass_n = 1'b0;
            vec_n  = '0;
            cnt_n  = SET;
            st_n   = FIRST;
         end
         HOLD: begin
            cnt_n = cnt - 4'd1;
            st_n  = (cnt <= 4'd1) ? CHECK : HOLD;
         end
         CHECK: begin
            if (mis) begin
               err_n = (err == EMAX) ? err : err + 1'b1;
               if (!fev) begin
                  fev_n  = 1'b1;
                  fvec_n = vec;
               end
            end
            if (stop) begin
               st_n   = FIN;
               done_n = 1'b1;
               pass_n = err_n == '0;
            end else begin
               vec_n = vec + 1'b1;
               cnt_n = SET;
               st_n  = FIRST;
            end
         end
         default: st_n = IDLE;
      endcase
      busy_n = (st_n == HOLD) || (st_n == CHECK);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st   <= IDLE;
         vec  <= '0;
         cnt  <= '0;
         err  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         pass <= 1'b0;
         fev  <= 1'b0;
         fvec <= '0;
      end else begin
         st   <= st_n;
         vec  <= vec_n;
         cnt  <= cnt_n;
         err  <= err_n;
         busy <= busy_n;
         done <= done_n;
         pass <= pass_n;
         fev  <= fev_n;
         fvec <= fvec_n;
      end
   end
   assign bus.vec_o           = vec;
   assign bus.busy            = busy;
   assign bus.done            = done;
   assign bus.pass            = pass;
   assign bus.err_cnt         = err;
   assign bus.first_err_valid = fev;
   assign bus.first_err_vec   = fvec;
endmodule

// File: tb/tb_adder4_stim_checker.sv
// tb_adder4_stim_checker: randomized scoreboard bench for two checker configurations
module tb_adder4_stim_checker;
   typedef struct {
      int ecnt;
      int ps;
      int fev;
      int fvec;
      int lastvec;
      int dcyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   nchk = 0;
   int   nfail = 0;
   int   mode = 0;
   logic [15:0] bad = '0;
   exp_t qa[$];
   exp_t qb[$];
   int   pda = 0;
   int   pdb = 0;
   adder4_stim_checker_if #(.N_IN(4), .RES_W(3), .ERR_W(5)) ia ();
   adder4_stim_checker_if #(.N_IN(4), .RES_W(3), .ERR_W(3)) ib ();
   adder4_stim_checker #(.N_IN(4), .RES_W(3), .SETTLE_CYC(1), .ERR_W(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ia));
   adder4_stim_checker #(.N_IN(4), .RES_W(3), .SETTLE_CYC(0), .ERR_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ib));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Behavioural adder with selectable faults: 0 good, 1 stuck-zero output,
   // 2 sum bit stuck at 0, 3 sum bit flipped on vectors flagged in bad.
   function automatic logic [2:0] adder_out(input logic [3:0] v, input int m, input logic [15:0] b);
      logic [2:0] pc;
      pc = 3'($countones(v));
      return (m == 1) ? 3'b000 : (m == 2) ? (pc & 3'b110) : (m == 3 && b[v]) ? (pc ^ 3'b001) : pc;
   endfunction
   assign ia.res_i = adder_out(ia.vec_o, mode, bad);
   assign ib.res_i = adder_out(ib.vec_o, mode, bad);
   // Expected outcome of one sweep, derived from the whole truth table at once.
   function automatic exp_t model(input int m, input logic [15:0] b, input int settle,
                                  input int errw, input int acc);
      exp_t e;
      int n, first, nvec;
      n = 0;
      first = -1;
      nvec = 16;
      for (int v = 0; v < 16; v++) begin
         if (int'(adder_out(4'(v), m, b)) != $countones(v)) begin
            n++;
            if (first < 0) first = v;
         end
`ifdef ADDER4_STOP_ON_ERR_EN
         if (first >= 0 && nvec == 16) nvec = v + 1;
`endif
      end
`ifdef ADDER4_STOP_ON_ERR_EN
      if (n > 1) n = 1;
`endif
      e.ecnt    = (n > (1 << errw) - 1) ? (1 << errw) - 1 : n;
      e.ps      = (n == 0) ? 1 : 0;
      e.fev     = (first >= 0) ? 1 : 0;
      e.fvec    = first;
      e.lastvec = (nvec == 16) ? 15 : first;
      e.dcyc    = acc + nvec * (settle + 1);
      return e;
   endfunction
   task automatic chk(input string n, input int a, input int x);
      nchk++;
      if (a != x) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", n, a, x);
      end
   endtask
   task automatic score(input string t, input exp_t e, input int ec, input int ps,
                        input int fev, input int fvec, input int vec);
      chk({"err_cnt_", t}, ec, e.ecnt);
      chk({"pass_", t}, ps, e.ps);
      chk({"first_err_valid_", t}, fev, e.fev);
      if (e.fev != 0) chk({"first_err_vec_", t}, fvec, e.fvec);
      chk({"vec_at_done_", t}, vec, e.lastvec);
      chk({"done_cycle_", t}, cyc, e.dcyc);
   endtask
   always @(negedge clk) begin
      if (rst_n && pda != 0) chk("done_width_a", int'(ia.done), 0);
      if (rst_n && ia.done) begin
         if (qa.size() == 0) chk("unexpected_done_a", 1, 0);
         else score("a", qa.pop_front(), int'(ia.err_cnt), int'(ia.pass),
                    int'(ia.first_err_valid), int'(ia.first_err_vec), int'(ia.vec_o));
      end
      pda = int'(rst_n && ia.done);
   end
   always @(negedge clk) begin
      if (rst_n && pdb != 0) chk("done_width_b", int'(ib.done), 0);
      if (rst_n && ib.done) begin
         if (qb.size() == 0) chk("unexpected_done_b", 1, 0);
         else score("b", qb.pop_front(), int'(ib.err_cnt), int'(ib.pass),
                    int'(ib.first_err_valid), int'(ib.first_err_vec), int'(ib.vec_o));
      end
      pdb = int'(rst_n && ib.done);
   end
   task automatic set_start(input int d, input logic v);
      if (d == 0) ia.start = v;
      else ib.start = v;
   endtask
   // Issue a sweep at the current negedge; the next rising edge accepts it.
   task automatic sweep(input int d, input int m, input int extra);
      mode = m;
      if (d == 0) qa.push_back(model(m, bad, 1, 5, cyc + 1));
      else qb.push_back(model(m, bad, 0, 3, cyc + 1));
      set_start(d, 1'b1);
      @(negedge clk);
      set_start(d, 1'b0);
      chk(d == 0 ? "busy_after_start_a" : "busy_after_start_b",
          int'(d == 0 ? ia.busy : ib.busy), 1);
      if (extra != 0) begin
         repeat (3) @(negedge clk);
         set_start(d, 1'b1);
         @(negedge clk);
         set_start(d, 1'b0);
      end
   endtask
   task automatic drain(input int d);
      int left;
      left = 1;
      for (int i = 0; i < 200 && left != 0; i++) begin
         @(negedge clk);
         left = (d == 0) ? qa.size() : qb.size();
      end
      chk(d == 0 ? "sweep_timeout_a" : "sweep_timeout_b", left, 0);
      qa.delete();
      qb.delete();
      repeat (2) @(negedge clk);
      chk(d == 0 ? "busy_idle_a" : "busy_idle_b", int'(d == 0 ? ia.busy : ib.busy), 0);
   endtask
   initial begin
      int found;
      ia.start = 1'b0;
      ib.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_vec", int'(ia.vec_o), 0);
      chk("rst_busy", int'(ia.busy), 0);
      chk("rst_done", int'(ia.done), 0);
      chk("rst_pass", int'(ia.pass), 0);
      chk("rst_err", int'(ia.err_cnt), 0);
      chk("rst_fev", int'(ia.first_err_valid), 0);
      chk("rst_fvec", int'(ia.first_err_vec), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      sweep(0, 0, 0); drain(0);
      sweep(0, 1, 0); drain(0);
      sweep(0, 2, 0); drain(0);
      sweep(1, 2, 0); drain(1);
      sweep(1, 1, 0); drain(1);
      bad = 16'h0800;
      sweep(0, 3, 0); drain(0);
      bad = '0;
      sweep(0, 0, 1); drain(0);
      sweep(1, 0, 1); drain(1);
      // start held across the done cycle: ignored in FIN, accepted one cycle later
      sweep(1, 0, 0);
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         @(negedge clk);
         found = int'(ib.done);
      end
      chk("done_seen_b", found, 1);
      qb.push_back(model(0, bad, 0, 3, cyc + 2));
      ib.start = 1'b1;
      repeat (2) @(negedge clk);
      ib.start = 1'b0;
      drain(1);
      // asynchronous reset in the middle of a sweep
      sweep(0, 0, 0);
      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         @(negedge clk);
         found = int'(ia.vec_o == 4'd6);
      end
      chk("reached_vec6", found, 1);
      #2 rst_n = 1'b0;
      #1;
      qa.delete();
      chk("arst_vec", int'(ia.vec_o), 0);
      chk("arst_busy", int'(ia.busy), 0);
      chk("arst_err", int'(ia.err_cnt), 0);
      chk("arst_fev", int'(ia.first_err_valid), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      sweep(0, 0, 0); drain(0);
      for (int k = 0; k < 6; k++) begin
         bad = 16'($urandom) & 16'($urandom);
         sweep(k % 2, 3, 0);
         drain(k % 2);
      end
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
      $fatal(1, "timeout");
   end
endmodule
